dma_bus_master: RTL and testbench

Bus-initiator copy engine that drives the same 6502-style system bus (16-bit address, 8-bit data, active-low write enable) that the top-level address decoder, firmware ROM, RAM and GPU VRAM respond to. On a start pulse it requests the bus, then copies a block of bytes from a source address to a destination address, one read cycle and one write cycle per byte. Typical use is bulk VRAM/OAM fills from RAM or firmware while the CPU is held off through the bus request/grant handshake.

---
 rtl/dma_bus_master.sv | 87 ++++++++
 tb/tb_dma_bus_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_master.sv
// dma_bus_master: bus-initiator byte copy engine (read then write per byte) over the 6502-style system bus.
// Optional DMA_BUS_MASTER_VBLANK_SYNC_EN: after grant, hold the bus quiet until vblank_irq_B goes low.
module dma_bus_master #(
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk_12_5875,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          src_address,
  input  logic [15:0]          dst_address,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic [15:0]          cpu_address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 write_enable_B,
  input  logic                 vblank_irq_B
);
`ifdef DMA_BUS_MASTER_VBLANK_SYNC_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_VBL, S_READ, S_WRITE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WRITE, S_DONE} state_t;
  logic w_unused_vbl;
  assign w_unused_vbl = vblank_irq_B;
`endif
  state_t               r_state;
  logic [15:0]          r_src;
  logic [15:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [7:0]           r_data;
  logic [LEN_WIDTH-1:0] w_cnt_nx;
  logic                 w_own_rd;
  logic                 w_own_wr;
  assign w_cnt_nx = r_cnt + 1'b1;
  // Losing the grant simply stalls the current phase; nothing advances until it returns.
  always_ff @(posedge clk_12_5875 or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          if (length != '0) begin
            r_src   <= src_address;
            r_dst   <= dst_address;
            r_len   <= length;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end else r_state <= S_DONE;
        end
`ifdef DMA_BUS_MASTER_VBLANK_SYNC_EN
        S_REQ:      if (bus_grant) r_state <= S_WAIT_VBL;
        S_WAIT_VBL: if (!vblank_irq_B) r_state <= S_READ;
`else
        S_REQ:      if (bus_grant) r_state <= S_READ;
`endif
        S_READ: if (bus_grant) begin
          r_data  <= data_in;
          r_state <= S_WRITE;
        end
        S_WRITE: if (bus_grant) begin
          r_src   <= r_src + 16'd1;
          r_dst   <= r_dst + 16'd1;
          r_cnt   <= w_cnt_nx;
          r_state <= (w_cnt_nx == r_len) ? S_DONE : S_READ;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  assign w_own_rd       = bus_grant && (r_state == S_READ);
  assign w_own_wr       = bus_grant && (r_state == S_WRITE);
  assign cpu_address    = w_own_rd ? r_src : w_own_wr ? r_dst : 16'h0000;
  assign write_enable_B = !w_own_wr;
  assign data_out       = r_data;
  assign busy           = r_state != S_IDLE;
  assign done           = r_state == S_DONE;
  assign bus_req        = busy && !done;
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: random and directed copies checked against a byte-level memory model via a write scoreboard.
module tb_dma_bus_master;
`ifdef DMA_BUS_MASTER_VBLANK_SYNC_EN
  localparam int VB = 1;
`else
  localparam int VB = 0;
`endif
  logic clk_12_5875 = 1'b0;
  logic rst, start, busy, done, bus_req, bus_grant, write_enable_B, vblank_irq_B;
  logic [15:0] src_address, dst_address, cpu_address;
  logic [11:0] length;
  logic [7:0]  data_in, data_out;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  typedef struct {logic [15:0] a; logic [7:0] d; logic [7:0] prev;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  wr_t rv;
  int total = 0, bad = 0, pending_done = 0, act = 0, diff = 0;
  logic bus_req_seen = 1'b0, rnd_grant = 1'b0;
  logic [15:0] rs, rd;
  logic [11:0] rn;

  always #5 clk_12_5875 = ~clk_12_5875;

  dma_bus_master #(.LEN_WIDTH(12)) dut (
    .clk_12_5875(clk_12_5875), .rst(rst), .start(start),
    .src_address(src_address), .dst_address(dst_address), .length(length),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_grant(bus_grant),
    .cpu_address(cpu_address), .data_in(data_in), .data_out(data_out),
    .write_enable_B(write_enable_B), .vblank_irq_B(vblank_irq_B)
  );

  assign data_in = mem[cpu_address];
  always @(posedge clk_12_5875) if (!rst && !write_enable_B) mem[cpu_address] <= data_out;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic int lat(input int n);
    return (n == 0) ? 1 : 2 * n + 2 + VB;
  endfunction

  // Scoreboard monitor: every write strobe consumes one expected (address, data) pair.
  always @(negedge clk_12_5875) if (!rst) begin
    if (!write_enable_B) begin
      if (exp_q.size() == 0) chk("unexpected write", 32'(cpu_address), 32'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("write addr", 32'(cpu_address), 32'(mon_e.a));
        chk("write data", 32'(data_out), 32'(mon_e.d));
      end
    end
    if (done) begin
      chk("done before all writes", exp_q.size(), 0);
      chk("done without transfer", 32'(pending_done > 0), 1);
      if (pending_done > 0) pending_done--;
    end
    if (!bus_grant) begin
      chk("ungranted addr", 32'(cpu_address), 0);
      chk("ungranted we", 32'(write_enable_B), 1);
    end
    if (bus_req) bus_req_seen = 1'b1;
    chk("bus_req outside active", 32'(bus_req && (!busy || done)), 0);
  end

  always @(posedge clk_12_5875) if (rnd_grant) begin
    #1 bus_grant = $urandom_range(0, 3) != 0;
`ifndef DMA_BUS_MASTER_VBLANK_SYNC_EN
    vblank_irq_B = 1'($urandom_range(0, 1));
`endif
  end

  task automatic push_model(input logic [15:0] s, input logic [15:0] d, input logic [11:0] n);
    wr_t w;
    for (int i = 0; i < int'(n); i++) begin
      w.a = d + 16'(i);
      w.prev = ref_mem[w.a];
      w.d = ref_mem[s + 16'(i)];
      ref_mem[w.a] = w.d;
      exp_q.push_back(w);
    end
    pending_done++;
  endtask

  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [11:0] n);
    @(negedge clk_12_5875);
    src_address = s; dst_address = d; length = n; start = 1'b1;
    @(posedge clk_12_5875);
    #1 start = 1'b0;
    src_address = 16'($urandom); dst_address = 16'($urandom); length = 12'($urandom);
    push_model(s, d, n);
  endtask

  task automatic xfer(input logic [15:0] s, input logic [15:0] d, input logic [11:0] n, input int l);
    int cyc;
    issue(s, d, n);
    cyc = 0;
    do begin
      @(negedge clk_12_5875);
      cyc++;
    end while (!done && cyc < 20000);
    chk("done timeout", 32'(done), 1);
    if (l >= 0) chk("done cycle", cyc, l);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; start = 1'b0; bus_grant = 1'b1; vblank_irq_B = 1'b0;
    src_address = '0; dst_address = '0; length = '0;
    repeat (3) @(negedge clk_12_5875);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset bus_req", 32'(bus_req), 0);
    chk("reset addr", 32'(cpu_address), 0);
    chk("reset data_out", 32'(data_out), 0);
    chk("reset we", 32'(write_enable_B), 1);
    @(posedge clk_12_5875);
    #1 rst = 1'b0;

    mem[16'h0200] = 8'hA5; mem[16'h0201] = 8'h5A; mem[16'h0202] = 8'hFF;
    ref_mem[16'h0200] = 8'hA5; ref_mem[16'h0201] = 8'h5A; ref_mem[16'h0202] = 8'hFF;
    xfer(16'h0200, 16'h4000, 12'd3, lat(3));
    // We are now in the DONE cycle; a start here must be dropped.
    src_address = 16'h0300; dst_address = 16'h0400; length = 12'd5; start = 1'b1;
    @(posedge clk_12_5875);
    #1 start = 1'b0;
    @(negedge clk_12_5875);
    chk("start in DONE ignored", 32'(busy), 0);

    bus_req_seen = 1'b0;
    xfer(16'h1234, 16'h5678, 12'd0, lat(0));
    chk("len0 busy in cycle 1", 32'(busy), 1);
    @(negedge clk_12_5875);
    chk("len0 busy after", 32'(busy), 0);
    chk("len0 bus_req", 32'(bus_req_seen), 0);

    xfer(16'hFFFF, 16'hFFFE, 12'd3, lat(3));

    fork
      xfer(16'h3000, 16'h3100, 12'd3, lat(3) + 5);
      begin
        @(negedge clk_12_5875);
        repeat (5 + VB) @(posedge clk_12_5875);
        #1 bus_grant = 1'b0;
        repeat (5) @(posedge clk_12_5875);
        #1 bus_grant = 1'b1;
      end
    join

    issue(16'h1000, 16'h2000, 12'd4);
    repeat (4 + VB) @(negedge clk_12_5875);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst bus_req", 32'(bus_req), 0);
    chk("midrst addr", 32'(cpu_address), 0);
    chk("midrst we", 32'(write_enable_B), 1);
    chk("midrst data_out", 32'(data_out), 0);
    chk("midrst pending writes", exp_q.size(), 3);
    while (exp_q.size() > 0) begin
      rv = exp_q.pop_back();
      ref_mem[rv.a] = rv.prev;
    end
    pending_done = 0;
    @(posedge clk_12_5875);
    #1 rst = 1'b0;
    xfer(16'h1000, 16'h2000, 12'd4, lat(4));

`ifdef DMA_BUS_MASTER_VBLANK_SYNC_EN
    vblank_irq_B = 1'b1;
    fork
      xfer(16'h5000, 16'h5100, 12'd2, -1);
      begin
        @(negedge clk_12_5875);
        @(posedge clk_12_5875);
        act = 0;
        repeat (20) begin
          @(negedge clk_12_5875);
          if (!write_enable_B || cpu_address != 16'h0000) act++;
        end
        chk("vblank hold quiet", act, 0);
        vblank_irq_B = 1'b0;
        @(negedge clk_12_5875);
        chk("vblank first read addr", 32'(cpu_address), 32'h5000);
      end
    join
`endif

    rnd_grant = 1'b1;
    repeat (30) begin
      rs = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      rn = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 12));
      xfer(rs, rd, rn, -1);
    end
    rnd_grant = 1'b0;
    @(posedge clk_12_5875);
    #2 bus_grant = 1'b1; vblank_irq_B = 1'b0;
    xfer(16'h0800, 16'h0900, 12'd6, lat(6));

    @(negedge clk_12_5875);
    diff = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("memory image", diff, 0);
    chk("leftover writes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
